// File: rtl/fault_inject_ctrl.sv
// fault_inject_ctrl: runtime single stuck-at fault injection controller.
// Walks every SA0/SA1 fault on the CUT inputs, forces the active fault onto
// the pattern for the faulty CUT copy, and counts faults whose outputs
// diverged from the fault-free copy.
// Optional feature macro: FIL_MAP_EN adds a per-site detection map (det_map).
module fault_inject_ctrl #(
    parameter int IN_BITS  = 5,
    parameter int OUT_BITS = 2,
    parameter int CNT_W    = 8,
    localparam int FW      = $clog2(2 * IN_BITS)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic                FIL_INC,
    input  logic [IN_BITS-1:0]  TEST_IP,
    input  logic [OUT_BITS-1:0] CUT_OP,
    input  logic [OUT_BITS-1:0] FF_OP,
    output logic [IN_BITS-1:0]  FAULT_IP,
    output logic [FW-1:0]       fault_idx,
    output logic                fault_active,
    output logic                detected,
    output logic [CNT_W-1:0]    det_count,
    output logic                done
`ifdef FIL_MAP_EN
    ,
    output logic [2*IN_BITS-1:0] det_map
`endif
);

    // Last fault site: SA1 on the top input bit.
    localparam logic [FW-1:0] LAST_IDX = FW'(2 * IN_BITS - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        INJECT = 2'd1,
        DONE   = 2'd2
    } state_t;

    state_t state_q;
    state_t state_d;
    logic   mismatch;
    logic   retire_hit;

    // Counter increment that sticks at all-ones instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    assign mismatch   = (CUT_OP != FF_OP);
    // A fault counts as detected if it diverged earlier or on the retire cycle.
    assign retire_hit = detected | mismatch;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state decode, status flags and fault forcing on the pattern.
    always_comb begin
        state_d      = state_q;
        fault_active = 1'b0;
        done         = 1'b0;
        FAULT_IP     = TEST_IP;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = INJECT;
                end
            end
            INJECT: begin
                fault_active = 1'b1;
                if (FIL_INC && (fault_idx == LAST_IDX)) begin
                    state_d = DONE;
                end
                // Low half of the index space is SA0, high half is SA1.
                for (int i = 0; i < IN_BITS; i++) begin
                    if (fault_idx == FW'(i)) begin
                        FAULT_IP[i] = 1'b0;
                    end else if (fault_idx == FW'(i + IN_BITS)) begin
                        FAULT_IP[i] = 1'b1;
                    end
                end
            end
            DONE: begin
                done = 1'b1;
                if (start) begin
                    state_d = INJECT;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Fault index, sticky detect flag and detected-fault counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            fault_idx <= '0;
            detected  <= 1'b0;
            det_count <= '0;
        end else begin
            case (state_q)
                IDLE, DONE: begin
                    if (start) begin
                        fault_idx <= '0;
                        detected  <= 1'b0;
                        det_count <= '0;
                    end
                end
                INJECT: begin
                    if (FIL_INC) begin
                        detected <= 1'b0;
                        if (retire_hit) begin
                            det_count <= sat_inc(det_count);
                        end
                        // The final fault holds its index into DONE.
                        if (fault_idx != LAST_IDX) begin
                            fault_idx <= fault_idx + 1'b1;
                        end
                    end else if (mismatch) begin
                        detected <= 1'b1;
                    end
                end
                default: begin
                    detected <= 1'b0;
                end
            endcase
        end
    end

`ifdef FIL_MAP_EN
    // Per-site coverage: mark each fault retired as detected.
    always_ff @(posedge clk) begin
        if (rst) begin
            det_map <= '0;
        end else if ((state_q == IDLE || state_q == DONE) && start) begin
            det_map <= '0;
        end else if (state_q == INJECT && FIL_INC && retire_hit) begin
            for (int k = 0; k < 2 * IN_BITS; k++) begin
                if (fault_idx == FW'(k)) begin
                    det_map[k] <= 1'b1;
                end
            end
        end
    end
`endif

endmodule

// File: tb/tb_fault_inject_ctrl.sv
// Directed testbench for fault_inject_ctrl (IN_BITS=5, OUT_BITS=2, CNT_W=8).
module tb_fault_inject_ctrl;

    logic       clk;
    logic       rst;
    logic       start;
    logic       fil_inc;
    logic [4:0] test_ip;
    logic [1:0] cut_op;
    logic [1:0] ff_op;
    logic [4:0] fault_ip;
    logic [3:0] fault_idx;
    logic       fault_active;
    logic       detected;
    logic [7:0] det_count;
    logic       done;
`ifdef FIL_MAP_EN
    logic [9:0] det_map;
`endif

    int errors = 0;
    int checks = 0;

    fault_inject_ctrl #(
        .IN_BITS (5),
        .OUT_BITS(2),
        .CNT_W   (8)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .FIL_INC     (fil_inc),
        .TEST_IP     (test_ip),
        .CUT_OP      (cut_op),
        .FF_OP       (ff_op),
        .FAULT_IP    (fault_ip),
        .fault_idx   (fault_idx),
        .fault_active(fault_active),
        .detected    (detected),
        .det_count   (det_count),
        .done        (done)
`ifdef FIL_MAP_EN
        ,
        .det_map     (det_map)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge, then settle away from the edge.
    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        rst     = 1'b1;
        start   = 1'b0;
        fil_inc = 1'b0;
        test_ip = 5'b10110;
        cut_op  = 2'b00;
        ff_op   = 2'b00;

        // Reset
        step();
        rst = 1'b0;
        #1;
        chk("rst_idx", 16'(fault_idx), 16'd0);
        chk("rst_active", 16'(fault_active), 16'd0);
        chk("rst_detected", 16'(detected), 16'd0);
        chk("rst_count", 16'(det_count), 16'd0);
        chk("rst_done", 16'(done), 16'd0);
        chk("rst_fault_ip", 16'(fault_ip), 16'b10110);

        // Decode walk
        start = 1'b1;
        step();
        start = 1'b0;
        chk("dec_active", 16'(fault_active), 16'd1);
        chk("dec_idx0_ip", 16'(fault_ip), 16'b10110);
        fil_inc = 1'b1;
        step();
        fil_inc = 1'b0;
        chk("dec_idx1", 16'(fault_idx), 16'd1);
        chk("dec_idx1_ip", 16'(fault_ip), 16'b10100);
        fil_inc = 1'b1;
        for (int i = 0; i < 4; i++) step();
        fil_inc = 1'b0;
        chk("dec_idx5", 16'(fault_idx), 16'd5);
        chk("dec_idx5_ip", 16'(fault_ip), 16'b10111);
        fil_inc = 1'b1;
        for (int i = 0; i < 4; i++) step();
        fil_inc = 1'b0;
        test_ip = 5'b00000;
        #1;
        chk("dec_idx9", 16'(fault_idx), 16'd9);
        chk("dec_idx9_ip", 16'(fault_ip), 16'b10000);
        chk("dec_count0", 16'(det_count), 16'd0);
        fil_inc = 1'b1;
        step();
        chk("dec_done", 16'(done), 16'd1);
        chk("dec_done_active", 16'(fault_active), 16'd0);
        chk("dec_done_idx", 16'(fault_idx), 16'd9);
        chk("dec_done_ip", 16'(fault_ip), 16'b00000);
        step();
        fil_inc = 1'b0;
        chk("done_filinc_idx", 16'(fault_idx), 16'd9);
        chk("done_filinc_done", 16'(done), 16'd1);

        // Detection with sticky flag
        test_ip = 5'b10110;
        start = 1'b1;
        step();
        start = 1'b0;
        chk("det_restart_done", 16'(done), 16'd0);
        chk("det_restart_idx", 16'(fault_idx), 16'd0);
        cut_op = 2'b01;
        step();
        cut_op = 2'b00;
        chk("det_sticky1", 16'(detected), 16'd1);
        step();
        chk("det_sticky2", 16'(detected), 16'd1);
        chk("det_count_pre", 16'(det_count), 16'd0);
        fil_inc = 1'b1;
        step();
        fil_inc = 1'b0;
        chk("det_count1", 16'(det_count), 16'd1);
        chk("det_cleared", 16'(detected), 16'd0);
        chk("det_idx1", 16'(fault_idx), 16'd1);

        // Mismatch on the retire cycle itself
        cut_op  = 2'b01;
        fil_inc = 1'b1;
        step();
        cut_op  = 2'b00;
        fil_inc = 1'b0;
        chk("sim_count2", 16'(det_count), 16'd2);
        chk("sim_detected", 16'(detected), 16'd0);
        chk("sim_idx2", 16'(fault_idx), 16'd2);

        // start is ignored mid-campaign
        start = 1'b1;
        step();
        start = 1'b0;
        chk("inj_start_idx", 16'(fault_idx), 16'd2);
        chk("inj_start_count", 16'(det_count), 16'd2);

        // Mid-campaign reset
        fil_inc = 1'b1;
        step();
        fil_inc = 1'b0;
        chk("mid_idx3", 16'(fault_idx), 16'd3);
        chk("mid_count2", 16'(det_count), 16'd2);
        rst = 1'b1;
        step();
        rst = 1'b0;
        test_ip = 5'b01101;
        #1;
        chk("mid_active", 16'(fault_active), 16'd0);
        chk("mid_idx0", 16'(fault_idx), 16'd0);
        chk("mid_count0", 16'(det_count), 16'd0);
        chk("mid_fault_ip", 16'(fault_ip), 16'b01101);

        // Full campaign, mismatch on even indices
        start = 1'b1;
        step();
        start = 1'b0;
        for (int i = 0; i < 10; i++) begin
            fil_inc = 1'b1;
            cut_op  = (i % 2 == 0) ? 2'b01 : 2'b00;
            step();
        end
        fil_inc = 1'b0;
        cut_op  = 2'b00;
        chk("cmp_count5", 16'(det_count), 16'd5);
        chk("cmp_done", 16'(done), 16'd1);
        chk("cmp_active", 16'(fault_active), 16'd0);
`ifdef FIL_MAP_EN
        chk("cmp_map", 16'(det_map), 16'b0101010101);
`endif
        fil_inc = 1'b1;
        cut_op  = 2'b10;
        step();
        fil_inc = 1'b0;
        cut_op  = 2'b00;
        chk("cmp_extra_count", 16'(det_count), 16'd5);
        start = 1'b1;
        step();
        start = 1'b0;
        chk("cmp_restart_count", 16'(det_count), 16'd0);
        chk("cmp_restart_done", 16'(done), 16'd0);
        chk("cmp_restart_active", 16'(fault_active), 16'd1);
`ifdef FIL_MAP_EN
        chk("cmp_restart_map", 16'(det_map), 16'd0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/fault_inject_ctrl.md
# fault_inject_ctrl

Runtime fault-injection controller for the LBIST mid section. It replaces per-fault netlist regeneration with a single elaborated design. The controller walks every single stuck-at fault on the CUT inputs (SA0 and SA1 per input bit) and forces the active fault onto the pattern fed to the faulty CUT copy. It compares faulty and fault-free CUT outputs and counts detected faults. It sits between the pattern generator (TEST_IP) and the two parallel CUT instances.

## Interface
- IN_BITS, 5, CUT input width; fault sites = 2*IN_BITS.
- OUT_BITS, 2, CUT output width.
- CNT_W, 8, width of detected-fault counter.
- Local FW = $clog2(2*IN_BITS), width of fault index.

- clk  in  1  clock, all state on rising edge.
- rst  in  1  reset, synchronous, active-high.
- start  in  1  begin campaign (honoured in IDLE and DONE only).
- FIL_INC  in  1  retire current fault, advance to next (honoured in INJECT only).
- TEST_IP  in  IN_BITS  test pattern from generator.
- CUT_OP  in  OUT_BITS  faulty CUT output.
- FF_OP  in  OUT_BITS  fault-free CUT output.
- FAULT_IP  out  IN_BITS  pattern with active fault applied; drives faulty CUT.
- fault_idx  out  FW  current fault index.
- fault_active  out  1  high in INJECT.
- detected  out  1  sticky: mismatch seen on current fault.
- det_count  out  CNT_W  number of retired faults that were detected.
- done  out  1  campaign complete.

## Operation
- States: IDLE, INJECT, DONE.
- Fault decode: k < IN_BITS → bit k stuck-at-0; k ≥ IN_BITS → bit (k−IN_BITS) stuck-at-1.
- FAULT_IP: in INJECT, TEST_IP with the decoded bit forced; in IDLE/DONE, equals TEST_IP.
- IDLE: start → INJECT, fault_idx=0, det_count=0, detected=0.
- INJECT, every cycle: if CUT_OP != FF_OP, detected←1 (sticky until retire).
- INJECT, FIL_INC: the fault is detected if detected==1 OR a mismatch occurs in the same cycle. A detected fault increments det_count, saturating at 2^CNT_W−1. detected←0.
  - If fault_idx < 2*IN_BITS−1: fault_idx+1.
  - Else: → DONE, done←1, fault_idx held.
- INJECT, start: ignored.
- DONE: FIL_INC ignored; outputs held.
  - start → INJECT, same as from IDLE: done←0, det_count cleared.
- rst overrides everything in any state, including mid-campaign.

## Timing
- Reset values: state IDLE; fault_idx 0, fault_active 0, detected 0, det_count 0, done 0. FAULT_IP = TEST_IP.
- FAULT_IP is combinational from TEST_IP and registered fault_idx/state: zero latency.
- The compare is combinational on same-cycle CUT_OP/FF_OP; detected is visible the cycle after the mismatch.
- det_count, fault_idx, done, and cleared detected are visible the cycle after the FIL_INC edge.
- fault_active rises the cycle after start and falls the cycle after the final FIL_INC.
- Minimum campaign: 1 start cycle + 2*IN_BITS FIL_INC cycles. FIL_INC may be held high for back-to-back advance, one fault per cycle.

## Configuration
- FIL_MAP_EN defined: adds output det_map [2*IN_BITS−1:0], reset 0, cleared on start.
  - Bit k is set when fault k is retired as detected, giving per-site coverage.
- FIL_MAP_EN undefined: port and register absent; all other behaviour identical.

## Test plan
All scenarios use IN_BITS=5, OUT_BITS=2, CNT_W=8.
- Reset: assert rst 1 cycle with TEST_IP=5'b10110 → all outputs zero, FAULT_IP=5'b10110.
- Decode: start, TEST_IP=5'b10110, then FIL_INC once.
  - fault_idx=1 → FAULT_IP=5'b10100.
  - Advance to fault_idx=5 → FAULT_IP=5'b10111.
  - At fault_idx=9 with TEST_IP=5'b00000 → FAULT_IP=5'b10000.
- Detection: in INJECT at idx 0, hold CUT_OP=2'b01, FF_OP=2'b00 one cycle, then equal outputs, then FIL_INC.
  - detected=1 before the FIL_INC.
  - After it: det_count=1, detected=0, fault_idx=1.
- Simultaneous: mismatch and FIL_INC in the same cycle, with detected=0 → det_count increments.
- Completion: start plus 10 consecutive FIL_INC, mismatch on even indices only.
  - det_count=5 and done=1 the cycle after the 10th FIL_INC; fault_active=0.
  - Extra FIL_INC leaves det_count=5.
  - start then restarts with det_count=0.
  - With FIL_MAP_EN defined: det_map=10'b0101010101.
- Mid-reset: rst at fault_idx=3 with det_count=2 → next cycle IDLE, fault_idx=0, det_count=0, FAULT_IP=TEST_IP.
